// File: rtl/butterfly_uart_serializer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : butterfly_uart_serializer_pkg
//  Description : Shared types and constants for the butterfly UART serializer.
//                Holds the frame-level FSM state encoding and the fixed frame
//                geometry (four words per butterfly result).
//  Revision    : 1.0 - initial release
// ============================================================================
package butterfly_uart_serializer_pkg;

    // One butterfly result is out0_re, out0_im, out1_re, out1_im.
    localparam int c_WORDS_PER_FRAME = 4;
    localparam int c_BITS_PER_BYTE   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : butterfly_uart_serializer_pkg
`default_nettype wire

// File: rtl/butterfly_uart_serializer_word_byte_select.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : word_byte_select
//  Description : Combinational byte slicer. Treats the four words as one
//                little-endian frame {word3, word2, word1, word0} and returns
//                byte[i_sel]; byte 0 is the LSB of word0.
//  Ports       : i_word0..i_word3  WORD_SIZE  frame words in transmit order
//                i_sel             CNT_W      byte index within the frame
//                o_byte            BYTE_WIDTH selected byte
//  Revision    : 1.0 - initial release
// ============================================================================
module word_byte_select
    import butterfly_uart_serializer_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int CNT_W      = 3
) (
    input  logic [WORD_SIZE-1:0]  i_word0,
    input  logic [WORD_SIZE-1:0]  i_word1,
    input  logic [WORD_SIZE-1:0]  i_word2,
    input  logic [WORD_SIZE-1:0]  i_word3,
    input  logic [CNT_W-1:0]      i_sel,
    output logic [BYTE_WIDTH-1:0] o_byte
);

    localparam int NUM_BYTES = c_WORDS_PER_FRAME * WORD_SIZE / c_BITS_PER_BYTE;

    logic [c_WORDS_PER_FRAME*WORD_SIZE-1:0] w_frame;
    logic [BYTE_WIDTH-1:0]                  w_bytes [NUM_BYTES];

    // Concatenating high word first makes byte k land at bits [8k +: 8].
    assign w_frame = {i_word3, i_word2, i_word1, i_word0};

    generate
        for (genvar g = 0; g < NUM_BYTES; g++) begin : g_bytes
            assign w_bytes[g] = w_frame[g*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    assign o_byte = w_bytes[i_sel];

endmodule : word_byte_select
`default_nettype wire

// File: rtl/butterfly_uart_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : butterfly_uart_serializer
//  Description : Captures one butterfly result on i_load and streams it to a
//                UART transmitter as bytes (LSB first, order out0_re, out0_im,
//                out1_re, out1_im) using a start/done handshake per byte.
//  Ports       : i_clk, i_rst (sync, active-low)
//                i_load, i_out0_re/im, i_out1_re/im   capture request + data
//                o_tx_start, o_tx_byte, i_tx_done      UART_TX handshake
//                o_busy, o_frame_done, o_overrun       status
//  Revision    : 1.0 - initial release
// ============================================================================
module butterfly_uart_serializer
    import butterfly_uart_serializer_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [WORD_SIZE-1:0]  i_out0_re,
    input  logic [WORD_SIZE-1:0]  i_out0_im,
    input  logic [WORD_SIZE-1:0]  i_out1_re,
    input  logic [WORD_SIZE-1:0]  i_out1_im,
    output logic                  o_tx_start,
    output logic [BYTE_WIDTH-1:0] o_tx_byte,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overrun
);

    localparam int NUM_BYTES = c_WORDS_PER_FRAME * WORD_SIZE / c_BITS_PER_BYTE;
    localparam int CNT_W     = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_BYTES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [WORD_SIZE-1:0]  r_out0_re, r_out0_im, r_out1_re, r_out1_im;
    logic [BYTE_WIDTH-1:0] r_tx_byte;
    logic                  r_overrun;

    logic                  w_load_accept;
    logic                  w_load_reject;
    logic                  w_advance;
    logic [WORD_SIZE-1:0]  w_sel_word0, w_sel_word1, w_sel_word2, w_sel_word3;
    logic [CNT_W-1:0]      w_sel_idx;
    logic [BYTE_WIDTH-1:0] w_next_byte;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_load_accept = 1'b0;
        w_advance     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_load_accept = 1'b1;
                    w_state_next  = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (r_cnt == c_LAST) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_START;
                    end
                end
            end
            ST_DONE: begin
                // Back-to-back frames: a load here is accepted like in IDLE.
                if (i_load) begin
                    w_load_accept = 1'b1;
                    w_state_next  = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_load_reject = i_load && ((r_state == ST_START) || (r_state == ST_WAIT));

    // The byte register is loaded on the edge that enters START, so the
    // byte is already valid in the START cycle. On a load the capture regs
    // are not yet written, so slice straight from the input words.
    assign w_sel_word0 = w_load_accept ? i_out0_re : r_out0_re;
    assign w_sel_word1 = w_load_accept ? i_out0_im : r_out0_im;
    assign w_sel_word2 = w_load_accept ? i_out1_re : r_out1_re;
    assign w_sel_word3 = w_load_accept ? i_out1_im : r_out1_im;
    assign w_sel_idx   = w_load_accept ? '0 : (r_cnt + CNT_W'(1));

    word_byte_select #(
        .WORD_SIZE  (WORD_SIZE),
        .BYTE_WIDTH (BYTE_WIDTH),
        .CNT_W      (CNT_W)
    ) u_word_byte_select (
        .i_word0 (w_sel_word0),
        .i_word1 (w_sel_word1),
        .i_word2 (w_sel_word2),
        .i_word3 (w_sel_word3),
        .i_sel   (w_sel_idx),
        .o_byte  (w_next_byte)
    );

    // ------------------------------------------------------------------
    // State, counter, capture and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_out0_re <= '0;
            r_out0_im <= '0;
            r_out1_re <= '0;
            r_out1_im <= '0;
            r_tx_byte <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load_accept) begin
                r_out0_re <= i_out0_re;
                r_out0_im <= i_out0_im;
                r_out1_re <= i_out1_re;
                r_out1_im <= i_out1_im;
                r_cnt     <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_advance) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_load_reject) begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_load_accept || w_advance) begin
                r_tx_byte <= w_next_byte;
            end
        end
    end

    assign o_tx_start   = (r_state == ST_START);
    assign o_busy       = (r_state == ST_START) || (r_state == ST_WAIT);
    assign o_frame_done = (r_state == ST_DONE);
    assign o_tx_byte    = r_tx_byte;
    assign o_overrun    = r_overrun;

endmodule : butterfly_uart_serializer
`default_nettype wire

// File: tb/tb_butterfly_uart_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_butterfly_uart_serializer
//  Description : Self-checking bench for butterfly_uart_serializer. Plays the
//                UART_TX side (returns i_tx_done after a chosen delay) and
//                compares every cycle against bytes computed from the words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_butterfly_uart_serializer;

    localparam int WS  = 16;
    localparam int NB  = 4 * WS / 8;
    localparam int BPW = WS / 8;

    typedef logic [WS-1:0] words_t [4];

    logic          clk;
    logic          rst;
    logic          load;
    logic [WS-1:0] out0_re, out0_im, out1_re, out1_im;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_done;
    logic          busy;
    logic          frame_done;
    logic          overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_fdone  = 0;

    butterfly_uart_serializer #(
        .WORD_SIZE  (WS),
        .BYTE_WIDTH (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load       (load),
        .i_out0_re    (out0_re),
        .i_out0_im    (out0_im),
        .i_out1_re    (out1_re),
        .i_out1_im    (out1_im),
        .o_tx_start   (tx_start),
        .o_tx_byte    (tx_byte),
        .i_tx_done    (tx_done),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_start)   n_starts++;
        if (frame_done) n_fdone++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: byte k is the (k mod bytes-per-word)-th little-endian byte
    // of word k / bytes-per-word.
    function automatic logic [7:0] model_byte(input words_t w, input int k);
        int unsigned v;
        v = int'(w[k / BPW]);
        return 8'((v / (32'd1 << (8 * (k % BPW)))) % 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input words_t w);
        out0_re = w[0];
        out0_im = w[1];
        out1_re = w[2];
        out1_im = w[3];
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_start"}, tx_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fdone"}, frame_done, 0);
    endtask

    // Apply a load in the current cycle; byte 0 must start the next cycle.
    task automatic do_load(input words_t w);
        set_words(w);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("load_start", tx_start, 1);
        check("load_byte0", tx_byte, model_byte(w, 0));
        check("load_busy", busy, 1);
        check("load_ovr_clr", overrun, 0);
    endtask

    // Called in the START cycle of byte 0. Returns in the DONE cycle unless
    // aborted by reset at byte abort_k.
    task automatic serve_frame(input words_t w, input int dmin, input int dmax,
                               input int ovr_k, input int abort_k,
                               input bit done_in_start, output bit aborted);
        words_t junk;
        int d;
        aborted = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (done_in_start && k == 0) tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("wait_start_low", tx_start, 0);
            check("wait_byte", tx_byte, model_byte(w, k));
            check("wait_busy", busy, 1);
            if (k == abort_k) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
                check_quiet("abort");
                check("abort_byte", tx_byte, 0);
                check("abort_ovr", overrun, 0);
                for (int i = 0; i < 4; i++) begin
                    tick();
                    check_quiet("abort_idle");
                end
                aborted = 1'b1;
                return;
            end
            d = int'($urandom_range(dmax, dmin));
            if (k == ovr_k && d < 1) d = 1;
            for (int i = 0; i < d; i++) begin
                if (k == ovr_k && i == 0) begin
                    foreach (junk[j]) junk[j] = WS'($urandom);
                    set_words(junk);
                    load = 1'b1;
                end
                tick();
                load = 1'b0;
                check("hold_start_low", tx_start, 0);
                check("hold_byte", tx_byte, model_byte(w, k));
                if (k == ovr_k && i == 0) check("overrun_set", overrun, 1);
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (k < NB - 1) begin
                check("next_start", tx_start, 1);
                check("next_byte", tx_byte, model_byte(w, k + 1));
                check("next_busy", busy, 1);
            end else begin
                check("fdone_pulse", frame_done, 1);
                check("fdone_busy", busy, 0);
                check("fdone_start", tx_start, 0);
            end
        end
    endtask

    initial begin : stim
        words_t w1, wa, wb, wc, wd, w6, wr;
        bit     ab;
        int     s0, f0;

        rst = 1'b0; load = 1'b0; tx_done = 1'b0;
        out0_re = '0; out0_im = '0; out1_re = '0; out1_im = '0;
        tick();
        tick();
        check_quiet("reset");
        check("reset_byte", tx_byte, 0);
        check("reset_ovr", overrun, 0);
        rst = 1'b1;
        tick();
        check_quiet("post_reset");

        // Fixed frame, done 20 cycles after every start.
        w1 = '{16'h0200, 16'h0100, 16'h0300, 16'hFF00};
        s0 = n_starts; f0 = n_fdone;
        do_load(w1);
        serve_frame(w1, 19, 19, -1, -1, 1'b0, ab);
        tick();
        check_quiet("t1_idle");
        check("t1_start_count", n_starts - s0, 8);
        check("t1_fdone_count", n_fdone - f0, 1);

        // Overrun during byte 3; remaining bytes still from first frame.
        foreach (wa[j]) wa[j] = WS'($urandom);
        do_load(wa);
        serve_frame(wa, 0, 4, 3, -1, 1'b0, ab);
        tick();
        check("ovr_sticky", overrun, 1);

        // Done in IDLE is ignored; done in START is ignored.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_quiet("idle_done_ign");
        check("idle_done_ovr", overrun, 1);
        foreach (wb[j]) wb[j] = WS'($urandom);
        do_load(wb);
        serve_frame(wb, 1, 3, -1, -1, 1'b1, ab);
        tick();

        // Reset in WAIT of byte 5, then a fresh frame restarts at byte 0.
        foreach (wc[j]) wc[j] = WS'($urandom);
        do_load(wc);
        serve_frame(wc, 0, 3, -1, 5, 1'b0, ab);
        check("abort_taken", 32'(ab), 1);
        foreach (wd[j]) wd[j] = WS'($urandom);
        do_load(wd);
        serve_frame(wd, 0, 2, -1, -1, 1'b0, ab);

        // Load in the DONE cycle chains straight into the next frame.
        w6 = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        do_load(w6);
        serve_frame(w6, 0, 3, -1, -1, 1'b0, ab);
        tick();
        check_quiet("t6_idle");

        // Random frames with random handshake delays and idle gaps.
        for (int f = 0; f < 4; f++) begin
            foreach (wr[j]) wr[j] = WS'($urandom);
            do_load(wr);
            serve_frame(wr, 0, 3, -1, -1, 1'b0, ab);
            tick();
            check_quiet("rand_idle");
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_butterfly_uart_serializer
`default_nettype wire
